// File: rtl/dmem_responder_if.sv
// Load/store port between the core memory stage and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-strobed word store / word load
// executed LATENCY cycles after acceptance, response held until consumed.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic        clk,
  input logic        reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           we_q;
  logic [31:0]    addr_q, wdata_q;
  logic [3:0]     wstrb_q;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           accept, exec;
  logic           a_we, a_err;
  logic [31:0]    a_addr, a_wdata;
  logic [3:0]     a_wstrb;
  logic [AW-1:0]  a_idx;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // With LATENCY=1 the access runs on the accept edge, so it must see the live request.
  always_comb begin
    if (state_q == IDLE) begin
      a_we    = bus.req_we;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
      a_wstrb = bus.req_wstrb;
    end else begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_wstrb = wstrb_q;
    end
    a_err = (a_addr[1:0] != 2'b00) || ((a_addr >> 2) >= 32'(DEPTH_WORDS));
    a_idx = a_addr[AW+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          exec    = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: if (cnt_q == CW'(1)) begin
        exec    = 1'b1;
        state_d = RESP;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (exec) begin
      err_d   = a_err;
      rdata_d = (a_err || a_we) ? 32'h0 : mem_q[a_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end

  // Storage is never reset; a store still counting down when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (exec && !reset && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wstrb[i]) mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for function/backpressure/reset, LATENCY=1 for back-to-back.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  // Issue one request and wait (bounded) for its response; lat = edges after accept
  // until rsp_valid is first seen high, -1 on timeout. rsp_ready is held high.
  task automatic xact(input bit b, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    if (b) begin
      ifb.req_valid = 1'b1; ifb.req_we = we; ifb.req_addr = addr;
      ifb.req_wdata = wdata; ifb.req_wstrb = strb; ifb.rsp_ready = 1'b1;
    end else begin
      ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_addr = addr;
      ifa.req_wdata = wdata; ifa.req_wstrb = strb; ifa.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
    lat = 0;
    while (!(b ? ifb.rsp_valid : ifa.rsp_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) lat = -1;
    rd  = b ? ifb.rsp_rdata : ifa.rsp_rdata;
    err = b ? ifb.rsp_err : ifa.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    nvec++; if (ifa.req_ready !== 1'b0) begin nerr++; $display("FAIL reset_req_ready got=%b exp=0", ifa.req_ready); end
    nvec++; if (ifa.rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid got=%b exp=0", ifa.rsp_valid); end
    nvec++; if (ifa.rsp_rdata !== 32'h0) begin nerr++; $display("FAIL reset_rsp_rdata got=%h exp=0", ifa.rsp_rdata); end
    nvec++; if (ifa.rsp_err !== 1'b0) begin nerr++; $display("FAIL reset_rsp_err got=%b exp=0", ifa.rsp_err); end
    nvec++; if (dut_a.cnt_q !== '0) begin nerr++; $display("FAIL reset_cnt got=%0d exp=0", dut_a.cnt_q); end
    reset = 1'b0;
    @(posedge clk); #1;
    nvec++; if (ifa.req_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready_a got=%b exp=1", ifa.req_ready); end
    nvec++; if (ifb.req_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready_b got=%b exp=1", ifb.req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; int lat;
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL st_latency got=%0d exp=1", lat); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL st_err got=%b exp=0", err); end
    nvec++; if (rd !== 32'h0) begin nerr++; $display("FAIL st_rdata got=%h exp=0", rd); end
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL ld_latency got=%0d exp=1", lat); end
    nvec++; if (rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL ld_err got=%b exp=0", err); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int lat;
    xact(0, 1'b1, 32'h10, 32'h11223344, 4'hF, rd, err, lat);
    xact(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, rd, err, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'h11BB33DD) begin nerr++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rd); end
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, err, lat);
    nvec++; if (err !== 1'b0 || lat !== 1) begin nerr++; $display("FAIL strobe_zero_rsp got err=%b lat=%0d exp err=0 lat=1", err, lat); end
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'h11BB33DD) begin nerr++; $display("FAIL strobe_zero_nochange got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat; int diffs;
    logic [31:0] snap [256];
    xact(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL misalign_err got=%b exp=1", err); end
    nvec++; if (rd !== 32'h0) begin nerr++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
    for (int j = 0; j < 256; j++) snap[j] = dut_a.mem_q[j];
    xact(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL oob_err got=%b exp=1", err); end
    nvec++; if (rd !== 32'h0) begin nerr++; $display("FAIL oob_rdata got=%h exp=0", rd); end
    diffs = 0;
    for (int j = 0; j < 256; j++) if (dut_a.mem_q[j] !== snap[j]) diffs++;
    nvec++; if (diffs != 0) begin nerr++; $display("FAIL oob_storage changed_words=%0d exp=0", diffs); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ifa.rsp_ready = 1'b0; ifa.req_valid = 1'b1; ifa.req_we = 1'b0; ifa.req_addr = 32'h10;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    @(posedge clk); #1;
    nvec++; if (ifa.rsp_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid_rise got=%b exp=1", ifa.rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      nvec++;
      if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== 32'h11BB33DD || ifa.rsp_err !== 1'b0 || ifa.req_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=11bb33dd e=0 rdy=0",
                 k, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err, ifa.req_ready);
      end
    end
    @(negedge clk);
    ifa.rsp_ready = 1'b1;
    @(posedge clk); #1;
    nvec++; if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", ifa.rsp_valid, ifa.req_ready);
    end
    nvec++; if (ifa.rsp_rdata !== 32'h0) begin nerr++; $display("FAIL bp_rdata_clear got=%h exp=0", ifa.rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat;
    xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, err, lat);
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 32'h20;
    ifa.req_wdata = 32'h12345678; ifa.req_wstrb = 4'hF; ifa.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    nvec++; if (ifa.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rm_wait_valid got=%b exp=0", ifa.rsp_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    nvec++; if (ifa.rsp_valid !== 1'b0 || ifa.rsp_rdata !== 32'h0 || ifa.rsp_err !== 1'b0 || ifa.req_ready !== 1'b0) begin
      nerr++; $display("FAIL rm_outputs got v=%b d=%h e=%b rdy=%b exp all 0", ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err, ifa.req_ready);
    end
    nvec++; if (dut_a.cnt_q !== '0) begin nerr++; $display("FAIL rm_cnt got=%0d exp=0", dut_a.cnt_q); end
    nvec++; if (dut_a.mem_q[8] !== 32'hCAFEF00D) begin nerr++; $display("FAIL rm_mem8 got=%h exp=cafef00d", dut_a.mem_q[8]); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      nvec++; if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin
        nerr++; $display("FAIL rm_after cyc=%0d got v=%b rdy=%b exp v=0 rdy=1", k, ifa.rsp_valid, ifa.req_ready);
      end
    end
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'hCAFEF00D) begin nerr++; $display("FAIL rm_load got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    xact(1, 1'b1, 32'h4, 32'h00000055, 4'hF, rd, err, lat);
    nvec++; if (lat !== 0) begin nerr++; $display("FAIL b2b_lat1 got=%0d exp=0", lat); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_addr = 32'(4 * i);
      ifb.req_wdata = 32'h100 + 32'(i); ifb.req_wstrb = 4'hF; ifb.rsp_ready = 1'b1;
      nvec++; if (ifb.req_ready !== ((i % 2) == 0) || ifb.rsp_valid !== ((i % 2) == 1)) begin
        nerr++; $display("FAIL b2b_cycle i=%0d got rdy=%b v=%b exp rdy=%b v=%b",
                         i, ifb.req_ready, ifb.rsp_valid, (i % 2) == 0, (i % 2) == 1);
      end
    end
    @(negedge clk);
    ifb.req_valid = 1'b0;
    xact(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'h100) begin nerr++; $display("FAIL b2b_w0 got=%h exp=100", rd); end
    xact(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'h55) begin nerr++; $display("FAIL b2b_w1 got=%h exp=55", rd); end
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'h102) begin nerr++; $display("FAIL b2b_w2 got=%h exp=102", rd); end
    xact(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    nvec++; if (rd !== 32'h104) begin nerr++; $display("FAIL b2b_w4 got=%h exp=104", rd); end
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifa.req_wstrb = '0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.req_wstrb = '0; ifb.rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_strobes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
